// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg -- shared definitions for the CPU control sequencer.
//   phase_t        : sub-phase encoding within one step (P0..P3)
//   STEP_COUNT_DEF : default number of steps per instruction cycle
//   fetch_ctl_t    : bundle of the eight fetch-cycle control lines
//   fetch_decode() : maps (step 1..3 active, enable window, set strobe)
//                    onto the fetch control lines
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_t;

  localparam int STEP_COUNT_DEF = 7;
  localparam int STEP_COUNT_MIN = 4;
  localparam int STEP_COUNT_MAX = 8;

  typedef struct packed {
    logic iar_e;
    logic bus1;
    logic mar_s;
    logic acc_s;
    logic ram_e;
    logic ir_s;
    logic acc_e;
    logic iar_s;
  } fetch_ctl_t;

  // Step 1: IAR onto bus, bus1 forces +1 at the ALU, latch MAR and ACC.
  // Step 2: RAM onto bus, latch IR.
  // Step 3: ACC onto bus, latch IAR.
  // Steps 4+ are decoded outside this block, so they produce nothing here.
  function automatic fetch_ctl_t fetch_decode(input logic s1, input logic s2,
                                              input logic s3, input logic en,
                                              input logic set);
    fetch_ctl_t f;
    f       = '0;
    f.iar_e = s1 & en;
    f.bus1  = s1 & en;
    f.mar_s = s1 & set;
    f.acc_s = s1 & set;
    f.ram_e = s2 & en;
    f.ir_s  = s2 & set;
    f.acc_e = s3 & en;
    f.iar_s = s3 & set;
    return f;
  endfunction

endpackage

// File: rtl/clk_phase_gen.sv
// clk_phase_gen -- four-phase generator for one sequencer step.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   stall      : hold the current phase (only ever raised while parked in P0)
//   phase      : registered current phase P0..P3
//   clk_e      : registered enable window, high in P1..P3
//   clk_s      : registered set strobe, high in P2
//   adv        : step-advance pulse, high during P3
//   e_nxt      : value clk_e takes after the next edge
//   s_nxt      : value clk_s takes after the next edge
// e_nxt/s_nxt let the parent register its decoded controls in the same
// edge as clk_e/clk_s, keeping every output glitch-free and aligned.
module clk_phase_gen
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  output logic [1:0] phase,
  output logic       clk_e,
  output logic       clk_s,
  output logic       adv,
  output logic       e_nxt,
  output logic       s_nxt
);

  phase_t ph_q, ph_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q  <= P0;
      clk_e <= 1'b0;
      clk_s <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      clk_e <= e_nxt;
      clk_s <= s_nxt;
    end
  end

  always_comb begin
    ph_d = ph_q;
    if (!stall) begin
      case (ph_q)
        P0:      ph_d = P1;
        P1:      ph_d = P2;
        P2:      ph_d = P3;
        P3:      ph_d = P0;
        default: ph_d = P0;
      endcase
    end
  end

  assign e_nxt = (ph_d != P0);
  assign s_nxt = (ph_d == P2);
  assign adv   = (ph_q == P3);
  assign phase = ph_q;

endmodule

// File: rtl/stepper_ctrl.sv
// stepper_ctrl -- instruction-cycle stepper: one-hot step ring, four
// phases per step, early termination and registered fetch decode.
// Parameter:
//   STEP_COUNT : steps per instruction cycle, legal range 4..8
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   end_step            : sampled in P3; restarts at step 1
//   halt                : (STEPPER_HALT_EN) sampled in P3; parks in P0 of
//                         the next step while held high
//   step                : one-hot current step, bit 0 = step 1
//   phase               : current phase P0..P3
//   clk_e / clk_s       : enable window (P1..P3) / set strobe (P2)
//   iar_e bus1 mar_s acc_s : step-1 fetch controls
//   ram_e ir_s          : step-2 fetch controls
//   acc_e iar_s         : step-3 fetch controls
//   halted              : (STEPPER_HALT_EN) high while parked
// Build option: define STEPPER_HALT_EN to add the halt/halted ports.
module stepper_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int STEP_COUNT = STEP_COUNT_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  end_step,
`ifdef STEPPER_HALT_EN
  input  logic                  halt,
  output logic                  halted,
`endif
  output logic [STEP_COUNT-1:0] step,
  output logic [1:0]            phase,
  output logic                  clk_e,
  output logic                  clk_s,
  output logic                  iar_e,
  output logic                  bus1,
  output logic                  mar_s,
  output logic                  acc_s,
  output logic                  ram_e,
  output logic                  ir_s,
  output logic                  acc_e,
  output logic                  iar_s
);

  localparam logic [STEP_COUNT-1:0] STEP1 = {{(STEP_COUNT-1){1'b0}}, 1'b1};

  logic [STEP_COUNT-1:0] step_q, step_d;
  logic                  adv, e_nxt, s_nxt, stall;
  fetch_ctl_t            fetch_q, fetch_d;

  // ---------------------------------------------------------------------
  // Park logic. Entering the park happens on the P3 -> P0 edge (the step
  // ring still advances), and the park persists as long as halt stays
  // high. The phase generator is only stalled once parked, so the first
  // low cycle of halt releases into P1 on the following edge.
  // ---------------------------------------------------------------------
`ifdef STEPPER_HALT_EN
  logic halted_q, halted_d;

  assign halted_d = halt & (adv | halted_q);
  assign stall    = halted_q & halt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) halted_q <= 1'b0;
    else          halted_q <= halted_d;
  end

  assign halted = halted_q;
`else
  assign stall = 1'b0;
`endif

  clk_phase_gen u_phase (
    .clk   (clk),
    .rst_n (reset_n),
    .stall (stall),
    .phase (phase),
    .clk_e (clk_e),
    .clk_s (clk_s),
    .adv   (adv),
    .e_nxt (e_nxt),
    .s_nxt (s_nxt)
  );

  // ---------------------------------------------------------------------
  // Step ring: moves only on the P3 -> P0 edge. end_step overrides the
  // rotation; outside P3 it has no effect.
  // ---------------------------------------------------------------------
  always_comb begin
    step_d = step_q;
    if (adv) begin
      if (end_step) step_d = STEP1;
      else          step_d = {step_q[STEP_COUNT-2:0], step_q[STEP_COUNT-1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) step_q <= STEP1;
    else          step_q <= step_d;
  end

  assign step = step_q;

  // ---------------------------------------------------------------------
  // Fetch decode from next-state values, then registered, so the controls
  // line up with clk_e/clk_s and never glitch.
  // ---------------------------------------------------------------------
  always_comb begin
    fetch_d = fetch_decode(step_d[0], step_d[1], step_d[2], e_nxt, s_nxt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fetch_q <= '0;
    else          fetch_q <= fetch_d;
  end

  assign iar_e = fetch_q.iar_e;
  assign bus1  = fetch_q.bus1;
  assign mar_s = fetch_q.mar_s;
  assign acc_s = fetch_q.acc_s;
  assign ram_e = fetch_q.ram_e;
  assign ir_s  = fetch_q.ir_s;
  assign acc_e = fetch_q.acc_e;
  assign iar_s = fetch_q.iar_s;

endmodule
